// File: rtl/branch_predictor_if.sv
// Fetch/resolve/redirect signal bundle for branch_predictor.
// master = pipeline side driving lookups and resolutions, slave = predictor.
interface branch_predictor_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic        resolve_valid;
  logic        resolve_is_branch;
  logic [31:0] resolve_pc;
  logic        resolve_pred_taken;
  logic        branch;
  logic [31:0] resolve_target;
  logic [31:0] resolve_fallthrough;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ready;

  modport master (
    output fetch_valid, fetch_pc,
    output resolve_valid, resolve_is_branch, resolve_pc, resolve_pred_taken,
    output branch, resolve_target, resolve_fallthrough,
    input  pred_valid, pred_taken, redirect, redirect_pc, ready
  );

  modport slave (
    input  fetch_valid, fetch_pc,
    input  resolve_valid, resolve_is_branch, resolve_pc, resolve_pred_taken,
    input  branch, resolve_target, resolve_fallthrough,
    output pred_valid, pred_taken, redirect, redirect_pc, ready
  );
endinterface

// File: rtl/branch_predictor.sv
// Per-PC 2-bit saturating-counter predictor with mispredict redirect.
// Optional macro BP_BYPASS_EN: same-cycle lookup sees the counter being trained.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 2 ** INDEX_BITS;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state_reg, state_next;
  logic [INDEX_BITS-1:0]   sweep_reg, sweep_next;
  logic [1:0]              table_mem [ENTRIES];

  logic                    table_we;
  logic [INDEX_BITS-1:0]   table_waddr;
  logic [1:0]              table_wdata;

  logic [INDEX_BITS-1:0]   fetch_idx;
  logic [INDEX_BITS-1:0]   resolve_idx;
  logic [1:0]              resolve_ctr;
  logic [1:0]              trained_ctr;
  logic                    train_req;
  logic                    mispredict;
  logic                    lookup_msb;

  logic                    pred_valid_reg;
  logic                    pred_taken_reg;
  logic                    redirect_reg;
  logic [31:0]             redirect_pc_reg;

  logic                    unused_pc_bits;

  assign fetch_idx   = bp.fetch_pc[INDEX_BITS+1:2];
  assign resolve_idx = bp.resolve_pc[INDEX_BITS+1:2];
  assign resolve_ctr = table_mem[resolve_idx];
  assign train_req   = bp.resolve_valid & bp.resolve_is_branch;
  assign mispredict  = train_req & (bp.branch != bp.resolve_pred_taken);

  // Only the index bits of each PC matter; the table is untagged.
  assign unused_pc_bits = ^{bp.fetch_pc[31:INDEX_BITS+2], bp.fetch_pc[1:0],
                            bp.resolve_pc[31:INDEX_BITS+2], bp.resolve_pc[1:0]};

  always_comb begin
    trained_ctr = resolve_ctr;
    if (bp.branch) begin
      if (resolve_ctr != 2'b11) trained_ctr = resolve_ctr + 2'd1;
    end else begin
      if (resolve_ctr != 2'b00) trained_ctr = resolve_ctr - 2'd1;
    end
  end

  // INIT owns the write port for the sweep; training only gets it in RUN.
  always_comb begin
    state_next  = state_reg;
    sweep_next  = sweep_reg;
    table_we    = 1'b0;
    table_waddr = resolve_idx;
    table_wdata = trained_ctr;
    case (state_reg)
      INIT: begin
        table_we    = 1'b1;
        table_waddr = sweep_reg;
        table_wdata = 2'b01;
        sweep_next  = sweep_reg + 1'b1;
        if (&sweep_reg) state_next = RUN;
      end
      RUN: begin
        table_we = train_req;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT;
      sweep_reg <= '0;
    end else begin
      state_reg <= state_next;
      sweep_reg <= sweep_next;
    end
  end

  always_ff @(posedge clk) begin
    if (table_we && !reset) table_mem[table_waddr] <= table_wdata;
  end

`ifdef BP_BYPASS_EN
  assign lookup_msb = (state_reg == RUN && train_req && resolve_idx == fetch_idx)
                      ? trained_ctr[1] : table_mem[fetch_idx][1];
`else
  assign lookup_msb = table_mem[fetch_idx][1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid_reg  <= 1'b0;
      pred_taken_reg  <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      pred_valid_reg <= bp.fetch_valid;
      pred_taken_reg <= (state_reg == RUN) & lookup_msb;
      redirect_reg   <= mispredict;
      if (mispredict)
        redirect_pc_reg <= bp.branch ? bp.resolve_target : bp.resolve_fallthrough;
    end
  end

  assign bp.pred_valid  = pred_valid_reg;
  assign bp.pred_taken  = pred_taken_reg;
  assign bp.redirect    = redirect_reg;
  assign bp.redirect_pc = redirect_pc_reg;
  assign bp.ready       = (state_reg == RUN);
endmodule
